// File: rtl/lift_request_queue.sv
`default_nettype none
// ============================================================================
//  Module      : lift_request_queue
//  Description : Hall-call request queue in front of the lift control FSM.
//                Edge-detects button presses, drops duplicates of requests
//                already pending, and queues them in arrival order. The
//                oldest request is presented as a one-hot word.
//  Revision    : 1.0  initial release
// ============================================================================
module lift_request_queue #(
    parameter int DEPTH = 6,
    parameter int NBTN  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] button_in,
    input  logic            pop,
    output logic [NBTN-1:0] button_out,
    output logic            q_empty,
    output logic [NBTN-1:0] pending,
    output logic [3:0]      count
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]         c_DEPTH = 4'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [NBTN-1:0]    c_ONE   = NBTN'(1);

    logic [NBTN-1:0]    r_btn_prev;
    logic [NBTN-1:0]    r_arrived;
    logic [NBTN-1:0]    r_pending;
    logic [2:0]         r_fifo [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [3:0]         r_count;

    logic [NBTN-1:0]    w_press;
    logic [NBTN-1:0]    w_push_oh;
    logic [NBTN-1:0]    w_head_oh;
    logic [2:0]         w_push_idx;
    logic [2:0]         w_head_idx;
    logic               w_pop_ok;
    logic               w_push;

    // A press is a rising edge on a button that is not already being served.
    assign w_press    = button_in & ~r_btn_prev & ~r_pending;
    assign w_pop_ok   = pop && (r_count != 4'd0);
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_push     = (r_arrived != '0) && ((r_count < c_DEPTH) || w_pop_ok);
    assign w_head_idx = r_fifo[r_rd_ptr];
    assign w_head_oh  = c_ONE << w_head_idx;
    assign w_push_oh  = w_push ? (c_ONE << w_push_idx) : '0;

    // Pick the lowest-index arrived button for this cycle's enqueue.
    always_comb begin
        w_push_idx = 3'd0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (r_arrived[i]) begin
                w_push_idx = 3'(i);
            end
        end
    end

    // Edge history, arrival set, lamp register, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_prev <= '1;
            r_arrived  <= '0;
            r_pending  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= 4'd0;
        end else begin
            r_btn_prev <= button_in;
            r_arrived  <= (r_arrived | w_press) & ~w_push_oh;
            // Moving a bit from arrived into the FIFO leaves its lamp lit;
            // only servicing the head clears it.
            r_pending  <= (r_pending | w_press) & ~(w_pop_ok ? w_head_oh : '0);
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop_ok})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; contents are only meaningful under the count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo[r_wr_ptr] <= w_push_idx;
        end
    end

    assign button_out = (r_count != 4'd0) ? w_head_oh : '0;
    assign q_empty    = (r_count == 4'd0);
    assign pending    = r_pending;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: doc/lift_request_queue.md
Name: lift_request_queue

Overview:
- Upstream stage of the lift control FSM.
- Captures raw hall-call button presses (1U, 2U, 3U, 2D, 3D, 4D), suppresses duplicates and holds them in arrival order in a FIFO.
- Presents the oldest request to the FSM as a one-hot button word, together with a queue-empty flag.
- The downstream ack logic pops the head when the FSM finishes servicing that request.

Parameters:
- DEPTH, 6, FIFO entries. Range 1..8. At 6, every distinct button can be queued at once.
- NBTN, 6, number of buttons. Fixed at 6. Bit order: 0=1U, 1=2U, 2=3U, 3=2D, 4=3D, 5=4D.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- button_in  input  6  raw button levels, already synchronous to clk; any number of bits may be high
- pop  input  1  one-cycle pulse: head request has been serviced
- button_out  output  6  one-hot head request; 6'b000000 when queue empty
- q_empty  output  1  high when FIFO holds no entries
- pending  output  6  per-button lamp: request arrived, queued, or at head and not yet popped
- count  output  4  number of FIFO entries, 0..DEPTH

Behaviour:
- Reset (rst high at clk edge) loads the following; it takes priority over every other event, including mid-operation:
  - FIFO empty; count=0; q_empty=1; button_out=0; pending=0.
  - Arrival register arrived=0.
  - btn_prev=6'b111111, so buttons held through reset are not taken as presses.
- Edge detect: press = button_in & ~btn_prev & ~pending. btn_prev <= button_in every non-reset cycle.
  - Holding a button generates exactly one press.
  - A press on a button whose pending bit is already set is discarded (dedup).
- Stage 1 (arrival): arrived <= (arrived | press) minus any bit moved to the FIFO this cycle.
  - Several presses in one cycle are all captured; none is lost.
- Stage 2 (enqueue): at most one push per cycle.
  - If arrived!=0 and (count<DEPTH or a pop occurs this cycle), the lowest-index arrived bit is written to the tail as a 3-bit index and cleared from arrived.
  - FIFO full and no pop: enqueue stalls; arrived keeps its bits. No overflow, no drop.
- pending = arrived | (OR of one-hot of all valid FIFO entries). Implement it as a register updated consistently with push/pop.
- Pop:
  - pop with count>0 removes the head, decrements count and clears that button's pending bit in the same edge.
  - pop with count==0 is ignored.
- Simultaneous push and pop with count>0: count unchanged; head advances; new entry goes to the tail.
  - When DEPTH is full, the freed slot is reused in the same cycle.
- Pointers: read/write pointers wrap modulo DEPTH. Full/empty are derived from count, not from pointer equality.
- Outputs are registered or decoded from registers only. No combinational path from button_in or pop to any output.
  - button_out = one-hot(head index) when count>0, else 0.
  - q_empty = (count==0).
- Latency:
  - Press seen at edge k sets arrived at k.
  - Push at edge k+1 if unblocked.
  - With an empty FIFO, button_out is valid and q_empty=0 after edge k+1 (2-cycle press-to-request).
- Re-press after pop: once pop clears pending, a new rising edge on that button is accepted. A level still held from before the pop is not a new edge.
- FSM interface: the FSM samples button_out/q_empty. The head stays stable until pop, regardless of new presses.

Test Plan:
- Reset then idle: rst high 2 cycles, button_in=0 -> q_empty=1, button_out=0, pending=0, count=0; a button held through reset produces no request after rst falls.
- Single press: button_in=6'b000100 for 1 cycle at edge k -> pending[2]=1 at k; after k+1 button_out=6'b000100, q_empty=0, count=1; pop pulse -> count=0, button_out=0, pending=0.
- Simultaneous presses: button_in=6'b100011 in one cycle -> FIFO order bit0, bit1, bit5 over 3 cycles, count reaches 3; three pops yield button_out 000001, 000010, 100000 in that sequence.
- Dedup and hold: press 2D (bit3), hold 10 cycles, release, press again before pop -> count stays 1; after pop, new press of 2D -> count=1 again.
- Full/stall with DEPTH=2: press bits 0,1,2 in one cycle -> count=2, arrived holds bit2 with pending[2]=1; pop+stall-release in same cycle -> count stays 2, tail now index 2, no request lost.
- Empty pop and reset mid-operation: pop with count=0 -> no change; with count=3 and pending=6'b010101, assert rst -> next cycle all outputs at reset values.
